nem_ohmux_sel_ctrl: RTL and testbench

- Sequential select controller sitting directly upstream of the NEM-relay one-hot inverting mux cells (4-input, 8-bit).
- Drives the mux select lines S0..S3 from an encoded select request through a valid/ready handshake.
- Enforces break-before-make timing for the mechanical relays: all selects released, pull-out wait, then the new select asserted, pull-in wait.
- Signals downstream logic when the mux output (ZN) is stable.

---
 rtl/nem_sel_pkg.sv | 30 +++
 rtl/nem_settle_timer.sv | 29 ++
 rtl/nem_ohmux_sel_ctrl.sv | 144 ++++++++++++++
 tb/tb_nem_ohmux_sel_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/nem_sel_pkg.sv
// Shared types, defaults and helpers for the NEM relay one-hot mux select controller.
package nem_sel_pkg;

   localparam int unsigned DEF_N_IN   = 4;
   localparam int unsigned DEF_SEL_W  = 2;
   localparam int unsigned DEF_T_OFF  = 8;
   localparam int unsigned DEF_T_ON   = 8;
   localparam int unsigned MAX_N_IN   = 32;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      BREAK = 2'd1,
      MAKE  = 2'd2,
      ON    = 2'd3
   } sel_state_e;

   // One-hot select vector for idx; all zero when disabled or idx is outside 0..n-1.
   function automatic logic [MAX_N_IN-1:0] onehot(input int unsigned idx,
                                                   input logic        en,
                                                   input int unsigned n);
      logic [MAX_N_IN-1:0] v;
      v = '0;
      if (en && (idx < n) && (idx < MAX_N_IN)) begin
         v[0] = 1'b1;
         v    = v << idx;
      end
      return v;
   endfunction

endpackage

// File: rtl/nem_settle_timer.sv
// Loadable down-counter that times relay pull-out / pull-in settling.
module nem_settle_timer #(
   parameter int unsigned CNT_W   = 4,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero_c
);

   logic [CNT_W-1:0] cnt;

   // Reset preloads the release wait; load wins over decrement; holds at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= CNT_W'(RST_VAL);
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero_c = (cnt == '0);

endmodule

// File: rtl/nem_ohmux_sel_ctrl.sv
// Break-before-make select sequencer for the NEM-relay one-hot inverting mux.
module nem_ohmux_sel_ctrl
   import nem_sel_pkg::*;
#(
   parameter int unsigned N_IN  = DEF_N_IN,
   parameter int unsigned SEL_W = DEF_SEL_W,
   parameter int unsigned T_OFF = DEF_T_OFF,
   parameter int unsigned T_ON  = DEF_T_ON,
   parameter int unsigned CNT_W = $clog2(((T_OFF > T_ON) ? T_OFF : T_ON) + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_en,
   input  logic [SEL_W-1:0] req_sel,
   output logic [N_IN-1:0]  S,
   output logic             settled,
   output logic             sel_err
);

   sel_state_e       state, state_d;
   logic [SEL_W-1:0] tgt_idx, tgt_idx_d;
   logic             tgt_en, tgt_en_d;
   logic [SEL_W-1:0] cur_idx, cur_idx_d;
   logic [N_IN-1:0]  s_d;
   logic             settled_d, ready_d, err_d;
   logic             tmr_load, tmr_dec, tmr_zero_c;
   logic [CNT_W-1:0] tmr_val;
   logic             accept_c, req_ok_c;

   assign accept_c = req_valid & req_ready;
   assign req_ok_c = req_en & (32'(req_sel) < N_IN);

   nem_settle_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (T_OFF - 1)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero_c   (tmr_zero_c)
   );

   // State and registered outputs; reset forces a full release wait since relay position is unknown.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= BREAK;
         tgt_idx   <= '0;
         tgt_en    <= 1'b0;
         cur_idx   <= '0;
         S         <= '0;
         settled   <= 1'b0;
         req_ready <= 1'b0;
         sel_err   <= 1'b0;
      end else begin
         state     <= state_d;
         tgt_idx   <= tgt_idx_d;
         tgt_en    <= tgt_en_d;
         cur_idx   <= cur_idx_d;
         S         <= s_d;
         settled   <= settled_d;
         req_ready <= ready_d;
         sel_err   <= err_d;
      end
   end

   // Next-state and output decode; S only ever moves between zero and a single one-hot value.
   always_comb begin
      state_d   = state;
      tgt_idx_d = tgt_idx;
      tgt_en_d  = tgt_en;
      cur_idx_d = cur_idx;
      s_d       = S;
      settled_d = settled;
      ready_d   = req_ready;
      err_d     = 1'b0;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      tmr_dec   = (state == BREAK) || (state == MAKE);

      case (state)
         OFF: begin
            if (accept_c) begin
               err_d = req_en & ~req_ok_c;
               if (req_ok_c) begin
                  state_d   = MAKE;
                  tgt_idx_d = req_sel;
                  tgt_en_d  = 1'b1;
                  s_d       = N_IN'(onehot(32'(req_sel), 1'b1, N_IN));
                  tmr_load  = 1'b1;
                  tmr_val   = CNT_W'(T_ON - 1);
                  settled_d = 1'b0;
                  ready_d   = 1'b0;
               end
            end
         end
         ON: begin
            if (accept_c) begin
               err_d = req_en & ~req_ok_c;
               if (!(req_ok_c && (req_sel == cur_idx))) begin
                  state_d   = BREAK;
                  tgt_idx_d = req_sel;
                  tgt_en_d  = req_ok_c;
                  s_d       = '0;
                  tmr_load  = 1'b1;
                  tmr_val   = CNT_W'(T_OFF - 1);
                  settled_d = 1'b0;
                  ready_d   = 1'b0;
               end
            end
         end
         BREAK: begin
            if (tmr_zero_c) begin
               if (tgt_en) begin
                  state_d  = MAKE;
                  s_d      = N_IN'(onehot(32'(tgt_idx), 1'b1, N_IN));
                  tmr_load = 1'b1;
                  tmr_val  = CNT_W'(T_ON - 1);
               end else begin
                  state_d   = OFF;
                  settled_d = 1'b1;
                  ready_d   = 1'b1;
               end
            end
         end
         MAKE: begin
            if (tmr_zero_c) begin
               state_d   = ON;
               cur_idx_d = tgt_idx;
               settled_d = 1'b1;
               ready_d   = 1'b1;
            end
         end
         default: begin
            state_d = BREAK;
            s_d     = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// Scoreboard bench: stimulus queues per-cycle expectations, monitor pops and compares.
module tb_nem_ohmux_sel_ctrl;

   localparam int unsigned T_OFF = 3;
   localparam int unsigned T_ON  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       v0, en0, rdy0, st0, err0;
   logic [1:0] sel0;
   logic [3:0] s0;
   logic       v1, en1, rdy1, st1, err1;
   logic [1:0] sel1;
   logic [2:0] s1;

   nem_ohmux_sel_ctrl #(.N_IN(4), .SEL_W(2), .T_OFF(T_OFF), .T_ON(T_ON)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0), .req_en(en0),
      .req_sel(sel0), .S(s0), .settled(st0), .sel_err(err0));

   nem_ohmux_sel_ctrl #(.N_IN(3), .SEL_W(2), .T_OFF(T_OFF), .T_ON(T_ON)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1), .req_en(en1),
      .req_sel(sel1), .S(s1), .settled(st1), .sel_err(err1));

   typedef struct {
      int         cyc;
      int         inst;
      logic [3:0] s;
      logic       st;
      logic       rdy;
      logic       err;
   } exp_t;

   exp_t q[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always @(posedge clk) cyc = cyc + 1;

   // Monitor: one-hot invariant every cycle, then every expectation due this cycle.
   always @(posedge clk) begin
      exp_t       e;
      logic [3:0] a_s;
      logic       a_st, a_rdy, a_err;
      #1;
      if (cyc >= 1) begin
         total++;
         if ($isunknown(s0) || ($countones(s0) > 1)) begin
            bad++;
            $display("FAIL onehot_dut4 cyc=%0d got S=%b need popcount<=1", cyc, s0);
         end
         total++;
         if ($isunknown(s1) || ($countones(s1) > 1)) begin
            bad++;
            $display("FAIL onehot_dut3 cyc=%0d got S=%b need popcount<=1", cyc, s1);
         end
      end
      while ((q.size() > 0) && (q[0].cyc <= cyc)) begin
         e = q.pop_front();
         if (e.inst == 0) begin
            a_s = s0; a_st = st0; a_rdy = rdy0; a_err = err0;
         end else begin
            a_s = {1'b0, s1}; a_st = st1; a_rdy = rdy1; a_err = err1;
         end
         total++;
         if ((e.cyc != cyc) || (a_s !== e.s) || (a_st !== e.st) ||
             (a_rdy !== e.rdy) || (a_err !== e.err)) begin
            bad++;
            $display("FAIL out_dut%0d cyc=%0d (due %0d) got S=%b settled=%b ready=%b err=%b need S=%b settled=%b ready=%b err=%b",
                     e.inst, cyc, e.cyc, a_s, a_st, a_rdy, a_err, e.s, e.st, e.rdy, e.err);
         end
      end
   end

   task automatic expect_at(input int c, input int inst, input logic [3:0] s,
                            input logic st, input logic rdy, input logic err);
      exp_t e;
      e = '{cyc: c, inst: inst, s: s, st: st, rdy: rdy, err: err};
      q.push_back(e);
   endtask

   task automatic expect_span(input int c0, input int c1, input int inst, input logic [3:0] s,
                              input logic st, input logic rdy, input logic err);
      for (int c = c0; c <= c1; c++) expect_at(c, inst, s, st, rdy, err);
   endtask

   // Both instances: full release wait after the last reset edge r, then idle in OFF.
   task automatic expect_reset(input int r);
      for (int c = r; c < r + int'(T_OFF); c++) begin
         expect_at(c, 0, 4'b0000, 1'b0, 1'b0, 1'b0);
         expect_at(c, 1, 4'b0000, 1'b0, 1'b0, 1'b0);
      end
      expect_at(r + int'(T_OFF), 0, 4'b0000, 1'b1, 1'b1, 1'b0);
      expect_at(r + int'(T_OFF), 1, 4'b0000, 1'b1, 1'b1, 1'b0);
   endtask

   // Present a request; k is the edge at which it will be accepted.
   task automatic start_req(input int inst, input logic en, input logic [1:0] sel, output int k);
      @(negedge clk);
      k = cyc + 1;
      if (inst == 0) begin
         v0 = 1'b1; en0 = en; sel0 = sel;
      end else begin
         v1 = 1'b1; en1 = en; sel1 = sel;
      end
   endtask

   task automatic end_req();
      @(negedge clk);
      v0 = 1'b0;
      v1 = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int r;
      rst_n = 1'b0;
      v0 = 1'b0; en0 = 1'b0; sel0 = 2'd0;
      v1 = 1'b0; en1 = 1'b0; sel1 = 2'd0;

      // Power-on reset released after two edges.
      @(negedge clk);
      r = cyc + 1;
      expect_reset(r);
      @(negedge clk);
      rst_n = 1'b1;
      wait_until(r + int'(T_OFF) + 1);

      // OFF -> connect input 2: immediate select, settled after T_ON.
      start_req(0, 1'b1, 2'd2, k);
      expect_span(k, k + 3, 0, 4'b0100, 1'b0, 1'b0, 1'b0);
      expect_at(k + 4, 0, 4'b0100, 1'b1, 1'b1, 1'b0);
      end_req();
      wait_until(k + 5);

      // ON(2) -> input 1: break for T_OFF, make for T_ON.
      start_req(0, 1'b1, 2'd1, k);
      expect_span(k, k + 2, 0, 4'b0000, 1'b0, 1'b0, 1'b0);
      expect_span(k + 3, k + 6, 0, 4'b0010, 1'b0, 1'b0, 1'b0);
      expect_at(k + 7, 0, 4'b0010, 1'b1, 1'b1, 1'b0);
      end_req();
      wait_until(k + 8);

      // ON(1) -> same input 1: no change.
      start_req(0, 1'b1, 2'd1, k);
      expect_span(k, k + 2, 0, 4'b0010, 1'b1, 1'b1, 1'b0);
      end_req();
      wait_until(k + 3);

      // ON(1) -> disconnect: break then OFF.
      start_req(0, 1'b0, 2'd0, k);
      expect_span(k, k + 2, 0, 4'b0000, 1'b0, 1'b0, 1'b0);
      expect_at(k + 3, 0, 4'b0000, 1'b1, 1'b1, 1'b0);
      end_req();
      wait_until(k + 4);

      // OFF -> disconnect: no-op.
      start_req(0, 1'b0, 2'd1, k);
      expect_span(k, k + 1, 0, 4'b0000, 1'b1, 1'b1, 1'b0);
      end_req();
      wait_until(k + 2);

      // N_IN=3, OFF -> invalid index 3: error pulse only, stays OFF.
      start_req(1, 1'b1, 2'd3, k);
      expect_at(k, 1, 4'b0000, 1'b1, 1'b1, 1'b1);
      expect_at(k + 1, 1, 4'b0000, 1'b1, 1'b1, 1'b0);
      end_req();
      wait_until(k + 2);

      // N_IN=3, OFF -> input 0.
      start_req(1, 1'b1, 2'd0, k);
      expect_span(k, k + 3, 1, 4'b0001, 1'b0, 1'b0, 1'b0);
      expect_at(k + 4, 1, 4'b0001, 1'b1, 1'b1, 1'b0);
      end_req();
      wait_until(k + 5);

      // N_IN=3, ON(0) -> invalid index 3: error pulse, break, final OFF.
      start_req(1, 1'b1, 2'd3, k);
      expect_at(k, 1, 4'b0000, 1'b0, 1'b0, 1'b1);
      expect_span(k + 1, k + 2, 1, 4'b0000, 1'b0, 1'b0, 1'b0);
      expect_at(k + 3, 1, 4'b0000, 1'b1, 1'b1, 1'b0);
      end_req();
      wait_until(k + 4);

      // Reset during MAKE: full break, target discarded, ends OFF.
      start_req(0, 1'b1, 2'd2, k);
      expect_span(k, k + 1, 0, 4'b0100, 1'b0, 1'b0, 1'b0);
      end_req();
      @(negedge clk);
      rst_n = 1'b0;
      r = cyc + 1;
      expect_reset(r);
      expect_at(r + int'(T_OFF) + 1, 0, 4'b0000, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_until(r + int'(T_OFF) + 2);

      @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain got pending=%0d need 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
